sample_fifo: RTL

SAMPLE_FIFO -- requirements
Module: sample_fifo

---
 rtl/sample_fifo.sv | 95 +++++++++
 1 files changed

// File: rtl/sample_fifo.sv
// Sample FIFO with no upstream back-pressure: samples that arrive while full are
// dropped and recorded in a sticky overflow flag and a saturating drop counter.
module sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf,
    output logic [7:0]                 drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       dropCnt_q, dropCnt_d;

    logic full;
    logic pop;
    logic push;
    logic drop;

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign full = (count_q == CW'(DEPTH));
    assign pop  = !rst && (count_q != '0) && out_rdy;
    assign push = !rst && in_vld && (!full || pop);
    assign drop = !rst && in_vld && !push;

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        dropCnt_d = dropCnt_q;

        if (push) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (drop) begin
            ovf_d = 1'b1;
            if (dropCnt_q != 8'hFF) begin
                dropCnt_d = dropCnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            dropCnt_q <= '0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            dropCnt_q <= dropCnt_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy alone says what is valid.
    always_ff @(posedge ck) begin
        if (push) begin
            mem_q[wrPtr_q] <= in_data;
        end
    end

    assign out_vld  = (count_q != '0);
    assign out_data = mem_q[rdPtr_q];
    assign count    = count_q;
    assign ovf      = ovf_q;
    assign drop_cnt = dropCnt_q;

endmodule
